hsi_tx_sequencer: RTL and testbench
===================================

HSI_TX_SEQUENCER -- requirements
Module: hsi_tx_sequencer

Interface
REQ-001 Parameter SOF_BYTE, default 8'h7E: start-of-frame byte sent first.
REQ-002 Parameter CRC_INIT, default 16'hFFFF: CRC seed loaded at frame start.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle frame request; sampled only in IDLE.
REQ-006 len  input  8  payload byte count; captured with start.
REQ-007 pl_data  input  8  payload byte from the upstream source.
REQ-008 pl_valid  input  1  pl_data is valid.
REQ-009 pl_ready  output  1  payload byte consumed this cycle.
REQ-010 cd_busy  input  1  byte coder is serializing; high from the cycle after cd_load until the byte is done.
REQ-011 cd_load  output  1  one-cycle strobe: coder takes cd_data.
REQ-012 cd_data  output  8  byte presented to the coder; valid while cd_load is high.
REQ-013 busy  output  1  frame in progress (state not IDLE).
REQ-014 msg_end  output  1  one-cycle pulse when the last CRC byte finishes serializing.

Function
REQ-015 States SHALL be IDLE, SOF, LEN, PAY, CRC_H, CRC_L, DONE; every state except IDLE and DONE is a byte state.
REQ-016 IDLE -> SOF when start=1; the block SHALL capture len, load CRC_INIT into crc_reg and clear the byte counter.
REQ-017 Each byte state has two phases, LOAD and WAIT.
REQ-018 LOAD: when cd_busy=0 and the byte is available, cd_load=1 for exactly one cycle; the block then enters WAIT.
REQ-019 WAIT: the block SHALL wait for cd_busy=1, then for cd_busy=0; on that falling edge it advances to the next state.
REQ-020 A cd_busy rise that does not follow cd_load SHALL be ignored.
REQ-021 SOF sends SOF_BYTE. LEN sends len. CRC_H sends crc_reg[15:8]. CRC_L sends crc_reg[7:0].
REQ-022 The CRC covers payload bytes only; SOF and LEN are excluded.
REQ-023 PAY, LOAD phase: the byte is available only when pl_valid=1.
REQ-024 On that cycle, pl_ready=1, cd_data=pl_data, cd_load=1 and the byte counter increments.
REQ-025 On that same edge, crc_reg SHALL update with pl_data using CRC-16/CCITT: polynomial 0x1021, MSB-first, no reflection, no final XOR.
REQ-026 pl_ready SHALL be 0 in every other cycle; a low pl_valid stalls PAY indefinitely with cd_load=0.
REQ-027 PAY exits to CRC_H after the WAIT of byte number len. If len=0, LEN goes directly to CRC_H and the CRC sent is CRC_INIT.
REQ-028 The byte counter is 8 bits and len=255 is legal; the counter SHALL be compared against len, never wrapped.
REQ-029 CRC_L completion -> DONE. DONE drives msg_end=1 for one cycle, then -> IDLE.
REQ-030 start outside IDLE, including in the DONE cycle, SHALL be ignored and SHALL NOT alter len or crc_reg.
REQ-031 cd_data SHALL hold the current state's byte in both phases, for observability.

Reset
REQ-032 n_rst=0 SHALL immediately force state IDLE, phase LOAD, crc_reg=CRC_INIT and byte counter=0.
REQ-033 During reset, cd_load, pl_ready, busy and msg_end SHALL be 0; cd_data and the captured len SHALL be 8'h00.
REQ-034 Reset mid-frame SHALL abandon the frame with no msg_end; the first frame after release starts cleanly from IDLE.

Structure
REQ-035 A shared package SHALL hold the state encoding, the CRC polynomial constant 16'h1021 and the SOF default.
REQ-036 One sub-module crc16_step SHALL hold the combinational next-CRC function: 16-bit crc and 8-bit data in, 16-bit crc out.

Verification
REQ-037 Basic frame. Stimulus: len=9, payload ASCII "123456789", coder busy 8 cycles per byte. Response: cd_data sequence 7E,09,31..39,29,B1; one msg_end pulse.
REQ-038 Empty payload. Stimulus: len=0. Response: bytes 7E,00,FF,FF; pl_ready never asserts.
REQ-039 Payload stall. Stimulus: pl_valid held low 20 cycles before byte 3. Response: no cd_load during the stall; CRC unchanged versus the unstalled run.
REQ-040 Ignored start. Stimulus: start pulsed during PAY and during DONE. Response: frame unaffected, a single msg_end, block returns to IDLE.
REQ-041 Mid-frame reset. Stimulus: n_rst low during CRC_H WAIT, then a new frame len=1, byte 00. Response: no msg_end for the aborted frame; new frame bytes 7E,01,00,E1,F0.
REQ-042 Spurious busy. Stimulus: cd_busy pulse in IDLE and in a LOAD phase before cd_load. Response: no state advance; each byte is loaded exactly once.

Source files
------------

// File: rtl/hsi_tx_sequencer_pkg.sv
// Shared definitions for the HSI transmit sequencer: state encoding,
// byte-phase encoding and CRC/framing constants.
package hsi_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        LEN,
        PAY,
        CRC_H,
        CRC_L,
        DONE
    } state_t;

    // Every byte state walks LOAD (hand byte to coder) then WAIT (coder busy).
    typedef enum logic {
        PH_LOAD,
        PH_WAIT
    } phase_t;

    localparam logic [15:0] CRC_POLY    = 16'h1021;
    localparam logic [7:0]  SOF_DEFAULT = 8'h7E;

endpackage

// File: rtl/hsi_tx_sequencer_crc16_step.sv
// One-byte CRC-16/CCITT update: MSB-first, no reflection, no final XOR.
module crc16_step
    import hsi_tx_sequencer_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] acc;

    // Fold the data byte into the top of the CRC, then shift out 8 bits.
    always_comb begin
        acc = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            acc = acc[15] ? ({acc[14:0], 1'b0} ^ CRC_POLY) : {acc[14:0], 1'b0};
        end
        crc_out = acc;
    end

endmodule

// File: rtl/hsi_tx_sequencer.sv
// Frame sequencer: SOF, length, payload and CRC bytes handed one at a time
// to a byte coder, pacing each byte on the coder's busy handshake.
module hsi_tx_sequencer
    import hsi_tx_sequencer_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE = SOF_DEFAULT,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic       cd_busy,
    output logic       cd_load,
    output logic [7:0] cd_data,
    output logic       busy,
    output logic       msg_end
);

    state_t      state_q, state_d, after_state;
    phase_t      phase_q, phase_d;
    logic        seen_q, seen_d;       // coder busy observed since our cd_load
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  hold_q, hold_d;       // payload byte last handed to the coder
    logic [15:0] crc_q, crc_d, crc_next;
    logic        byte_ok;

    crc16_step u_crc (
        .crc_in  (crc_q),
        .data    (pl_data),
        .crc_out (crc_next)
    );

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            phase_q <= PH_LOAD;
            seen_q  <= 1'b0;
            len_q   <= 8'h00;
            cnt_q   <= 8'h00;
            hold_q  <= 8'h00;
            crc_q   <= CRC_INIT;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            phase_q <= phase_d;
            seen_q  <= seen_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            crc_q   <= crc_d;
        end
    end

    // Next-state, byte selection and handshake outputs.
    always_comb begin
        // NOTE: every output and next value is defaulted first so no path infers a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        seen_d      = seen_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        crc_d       = crc_q;
        after_state = state_q;
        byte_ok     = 1'b1;
        cd_load     = 1'b0;
        pl_ready    = 1'b0;
        cd_data     = 8'h00;
        msg_end     = 1'b0;
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SOF;
                    phase_d = PH_LOAD;
                    seen_d  = 1'b0;
                    len_d   = len;
                    crc_d   = CRC_INIT;
                    cnt_d   = 8'h00;
                end
            end
            SOF: begin
                cd_data     = SOF_BYTE;
                after_state = LEN;
            end
            LEN: begin
                cd_data     = len_q;
                after_state = (len_q == 8'h00) ? CRC_H : PAY;
            end
            PAY: begin
                cd_data     = (phase_q == PH_LOAD) ? pl_data : hold_q;
                byte_ok     = pl_valid;
                after_state = (cnt_q == len_q) ? CRC_H : PAY;
            end
            CRC_H: begin
                cd_data     = crc_q[15:8];
                after_state = CRC_L;
            end
            CRC_L: begin
                cd_data     = crc_q[7:0];
                after_state = DONE;
            end
            DONE: begin
                msg_end = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Shared LOAD/WAIT handshake for all byte states.
        if (state_q inside {SOF, LEN, PAY, CRC_H, CRC_L}) begin
            if (phase_q == PH_LOAD) begin
                if (!cd_busy && byte_ok) begin
                    cd_load = 1'b1;
                    phase_d = PH_WAIT;
                    seen_d  = 1'b0;
                    if (state_q == PAY) begin
                        pl_ready = 1'b1;
                        cnt_d    = cnt_q + 8'd1;
                        crc_d    = crc_next;
                        hold_d   = pl_data;
                    end
                end
            end else if (!seen_q) begin
                if (cd_busy) seen_d = 1'b1;
            end else if (!cd_busy) begin
                state_d = after_state;
                phase_d = PH_LOAD;
                seen_d  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hsi_tx_sequencer.sv
// Scoreboard bench for hsi_tx_sequencer: frames push their expected coder
// bytes into a queue; a negedge monitor pops and compares on each cd_load.
module tb_hsi_tx_sequencer;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic [7:0] len;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       cd_busy;
    logic       cd_load;
    logic [7:0] cd_data;
    logic       busy;
    logic       msg_end;

    int          checks = 0;
    int          errors = 0;
    int          loads = 0;
    int          readys = 0;
    int          msg_ends = 0;
    int          busy_cycles = 8;
    bit          coder_active = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  pay[$];

    hsi_tx_sequencer dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .len      (len),
        .pl_data  (pl_data),
        .pl_valid (pl_valid),
        .pl_ready (pl_ready),
        .cd_busy  (cd_busy),
        .cd_load  (cd_load),
        .cd_data  (cd_data),
        .busy     (busy),
        .msg_end  (msg_end)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Independent bit-serial CRC-16/CCITT over the current payload.
    function automatic logic [15:0] crc_model(input logic [15:0] init);
        logic [15:0] c = init;
        logic        fb;
        foreach (pay[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ pay[i][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    // Monitor: compare every coder load against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (cd_load) begin
                loads++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: got %0h expected none", cd_data);
                end else begin
                    check("cd_data", {24'h0, cd_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (pl_ready) begin
                readys++;
                check("pl_ready_with_load", {31'h0, cd_load}, 32'h1);
            end
            if (msg_end) msg_ends++;
        end
    end

    // Coder model: busy from the cycle after cd_load for busy_cycles cycles.
    initial begin
        cd_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (cd_load) begin
                coder_active = 1'b1;
                @(posedge clk);
                #1 cd_busy = 1'b1;
                repeat (busy_cycles) @(posedge clk);
                #1 cd_busy = 1'b0;
                coder_active = 1'b0;
            end
        end
    end

    task automatic wait_loads(input int target, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            ok = (loads >= target);
        end
        if (!ok) fail_now(name);
    endtask

    task automatic wait_coder_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = !coder_active;
        end
        if (!ok) fail_now(name);
    endtask

    // Hand the payload queue to the DUT one byte per pl_ready.
    task automatic feed(input int stall_idx, input int start_idx, input string tag);
        int l1;
        bit got;
        for (int i = 0; i < pay.size(); i++) begin
            if (i == stall_idx) begin
                pl_valid = 1'b0;
                l1 = loads;
                repeat (20) @(posedge clk);
                #1 check({tag, "_no_load_in_stall"}, loads - l1, 0);
            end
            if (i == start_idx) begin
                @(posedge clk);
                #1 start = 1'b1; len = 8'hAA;
                @(posedge clk);
                #1 start = 1'b0; len = 8'h00;
            end
            pl_data  = pay[i];
            pl_valid = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 400 && !got; k++) begin
                @(negedge clk);
                got = pl_ready;
            end
            if (!got) fail_now({tag, "_pl_ready"});
            @(posedge clk);
            #1 pl_valid = 1'b0; pl_data = 8'h00;
        end
    endtask

    task automatic run_frame(input logic [7:0] ln, input logic [15:0] crc, input int stall_idx,
                             input int start_idx, input bit start_in_done, input bit spurious,
                             input string tag);
        int  l0, r0, m0;
        bit  got;
        exp_q.push_back(8'h7E);
        exp_q.push_back(ln);
        foreach (pay[i]) exp_q.push_back(pay[i]);
        exp_q.push_back(crc[15:8]);
        exp_q.push_back(crc[7:0]);
        l0 = loads; r0 = readys; m0 = msg_ends;

        @(posedge clk);
        #1 start = 1'b1; len = ln;
        @(posedge clk);
        #1 start = 1'b0; len = 8'h00;

        if (spurious) begin
            // Busy pulse while PAY sits in LOAD with a valid byte offered.
            wait_loads(l0 + 2, {tag, "_len_load"});
            wait_coder_idle({tag, "_coder_idle"});
            @(posedge clk);
            #1 cd_busy = 1'b1; pl_data = pay[0]; pl_valid = 1'b1;
            repeat (3) @(posedge clk);
            #1 cd_busy = 1'b0;
            check({tag, "_no_load_while_busy"}, loads - l0, 2);
        end

        feed(stall_idx, start_idx, tag);

        got = 1'b0;
        for (int k = 0; k < 5000 && !got; k++) begin
            @(negedge clk);
            got = msg_end;
        end
        if (!got) fail_now({tag, "_msg_end"});
        if (start_in_done) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check({tag, "_msg_end_one_cycle"}, {31'h0, msg_end}, 32'h0);
        check({tag, "_idle_after_done"}, {31'h0, busy}, 32'h0);
        repeat (5) @(negedge clk);
        check({tag, "_load_count"}, loads - l0, 32'(ln) + 4);
        check({tag, "_ready_count"}, readys - r0, 32'(ln));
        check({tag, "_msg_end_count"}, msg_ends - m0, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_still_idle"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int l0, m0;
        n_rst = 1'b0; start = 1'b0; len = 8'h00; pl_data = 8'h00; pl_valid = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_cd_load", {31'h0, cd_load}, 32'h0);
        check("rst_pl_ready", {31'h0, pl_ready}, 32'h0);
        check("rst_msg_end", {31'h0, msg_end}, 32'h0);
        check("rst_cd_data", {24'h0, cd_data}, 32'h0);
        @(negedge clk) n_rst = 1'b1;

        // Basic frame "123456789".
        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame(8'd9, 16'h29B1, -1, -1, 1'b0, 1'b0, "basic");

        // Empty payload.
        pay.delete();
        run_frame(8'd0, 16'hFFFF, -1, -1, 1'b0, 1'b0, "empty");

        // Stall before third payload byte; same CRC.
        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame(8'd9, 16'h29B1, 2, -1, 1'b0, 1'b0, "stall");

        // start pulsed in PAY (with a different len) and in DONE.
        run_frame(8'd9, 16'h29B1, -1, 4, 1'b1, 1'b0, "ign_start");

        // Spurious busy in IDLE, then in a PAY LOAD phase.
        l0 = loads;
        @(posedge clk);
        #1 cd_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 cd_busy = 1'b0;
        check("idle_spurious_busy", {31'h0, busy}, 32'h0);
        check("idle_spurious_loads", loads - l0, 0);
        pay = '{8'h00};
        run_frame(8'd1, 16'hE1F0, -1, -1, 1'b0, 1'b1, "spurious");

        // Mid-frame reset during CRC_H WAIT.
        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        exp_q.push_back(8'h7E);
        exp_q.push_back(8'h09);
        foreach (pay[i]) exp_q.push_back(pay[i]);
        exp_q.push_back(8'h29);
        l0 = loads; m0 = msg_ends;
        @(posedge clk);
        #1 start = 1'b1; len = 8'd9;
        @(posedge clk);
        #1 start = 1'b0; len = 8'h00;
        feed(-1, -1, "abort");
        wait_loads(l0 + 12, "abort_crc_h_load");
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("abort_rst_busy", {31'h0, busy}, 32'h0);
        check("abort_rst_cd_data", {24'h0, cd_data}, 32'h0);
        check("abort_rst_cd_load", {31'h0, cd_load}, 32'h0);
        repeat (12) @(posedge clk);
        check("abort_no_msg_end", msg_ends - m0, 0);
        exp_q.delete();
        @(negedge clk) n_rst = 1'b1;
        pay = '{8'h00};
        run_frame(8'd1, 16'hE1F0, -1, -1, 1'b0, 1'b0, "after_abort");

        // Maximum length, fast coder; CRC from the bench model.
        busy_cycles = 2;
        pay.delete();
        for (int i = 0; i < 255; i++) pay.push_back(8'(i));
        run_frame(8'd255, crc_model(16'hFFFF), -1, -1, 1'b0, 1'b0, "len255");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
